// File: rtl/ws2812_driver.sv
// WS2812 serial LED driver: streams one 24-bit GRB pixel per LED, then holds the latch gap.
// Optional: define WS2812_AUTO_REFRESH_EN to restart a frame after every latch without a start request.
module ws2812_driver #(
    parameter int unsigned T_BIT   = 62,
    parameter int unsigned T0H     = 20,
    parameter int unsigned T1H     = 40,
    parameter int unsigned T_LATCH = 15000,
    parameter int unsigned LED_NUM = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] color,
    output logic [5:0]  addr,
    output logic        busy,
    output logic        frame_done,
    output logic        dout
);

    localparam int unsigned BIT_W   = $clog2(T_BIT + 1);
    localparam int unsigned LATCH_W = $clog2(T_LATCH + 1);

    localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(T_BIT - 1);
    localparam logic [BIT_W-1:0]   HIGH_ONE   = BIT_W'(T1H);
    localparam logic [BIT_W-1:0]   HIGH_ZERO  = BIT_W'(T0H);
    localparam logic [LATCH_W-1:0] LATCH_LAST = LATCH_W'(T_LATCH - 1);
    localparam logic [5:0]         ADDR_LAST  = 6'(LED_NUM - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        LATCH
    } state_t;

    state_t             state,      state_next;
    logic [5:0]         addr_next;
    logic [BIT_W-1:0]   bit_cnt,    bit_cnt_next;
    logic [4:0]         bit_idx,    bit_idx_next;
    logic [23:0]        shift_reg,  shift_next;
    logic [LATCH_W-1:0] latch_cnt,  latch_cnt_next;
    logic               frame_done_next;
    logic               dout_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            latch_cnt  <= '0;
            frame_done <= 1'b0;
            dout       <= 1'b0;
        end else begin
            state      <= state_next;
            addr       <= addr_next;
            bit_cnt    <= bit_cnt_next;
            bit_idx    <= bit_idx_next;
            shift_reg  <= shift_next;
            latch_cnt  <= latch_cnt_next;
            frame_done <= frame_done_next;
            dout       <= dout_next;
        end
    end

    always_comb begin
        state_next      = state;
        addr_next       = addr;
        bit_cnt_next    = bit_cnt;
        bit_idx_next    = bit_idx;
        shift_next      = shift_reg;
        latch_cnt_next  = latch_cnt;
        frame_done_next = 1'b0;
        dout_next       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    addr_next  = '0;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                // Colour arrives as {R,G,B}; the LED expects green first.
                shift_next   = {color[15:8], color[23:16], color[7:0]};
                bit_cnt_next = '0;
                bit_idx_next = '0;
                state_next   = SEND;
            end
            SEND: begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_next = '0;
                    if (bit_idx == 5'd23) begin
                        if (addr == ADDR_LAST) begin
                            latch_cnt_next = '0;
                            state_next     = LATCH;
                        end else begin
                            addr_next  = addr + 6'd1;
                            state_next = LOAD;
                        end
                    end else begin
                        bit_idx_next = bit_idx + 5'd1;
                        shift_next   = {shift_reg[22:0], 1'b0};
                    end
                end else begin
                    bit_cnt_next = bit_cnt + BIT_W'(1);
                end
            end
            LATCH: begin
                if (latch_cnt == LATCH_LAST) begin
                    latch_cnt_next  = '0;
                    frame_done_next = 1'b1;
`ifdef WS2812_AUTO_REFRESH_EN
                    addr_next  = '0;
                    state_next = LOAD;
`else
                    state_next = IDLE;
`endif
                end else begin
                    latch_cnt_next = latch_cnt + LATCH_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        // dout is registered from next-state values so it lines up with bit_cnt without glitches.
        if (state_next == SEND) begin
            dout_next = (bit_cnt_next < (shift_next[23] ? HIGH_ONE : HIGH_ZERO));
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ws2812_driver.sv
// Scoreboard bench for ws2812_driver: expected pulses and frame_done cycles are queued at start, checked by a monitor.
module tb_ws2812_driver;

    localparam int unsigned TB    = 10;
    localparam int unsigned T0    = 3;
    localparam int unsigned T1    = 7;
    localparam int unsigned TL    = 40;
    localparam int unsigned LEDS  = 12;
    localparam int unsigned FRAME = LEDS * (24 * TB + 1) + TL;

    typedef struct packed {
        logic [31:0] rise;
        logic [31:0] width;
        logic [5:0]  addr;
    } bit_exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [23:0] color;
    logic [5:0]  addr;
    logic        busy;
    logic        frame_done;
    logic        dout;

    logic [23:0] color_tab [64];
    logic [23:0] grb_tab   [64];

    int unsigned cyc    = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    bit          mon_en = 1'b1;

    bit_exp_t    bit_q[$];
    int unsigned fd_q[$];

    bit          in_high   = 1'b0;
    int unsigned rise_cyc  = 0;
    int unsigned high_len  = 0;
    logic [5:0]  rise_addr = '0;

    assign color = color_tab[addr];

    ws2812_driver #(
        .T_BIT   (TB),
        .T0H     (T0),
        .T1H     (T1),
        .T_LATCH (TL),
        .LED_NUM (LEDS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .color      (color),
        .addr       (addr),
        .busy       (busy),
        .frame_done (frame_done),
        .dout       (dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // pattern 0: all FF0000, 1: all 000001, 2: four mixed colours repeating; GRB words are hand-derived
    task automatic fill(input int unsigned pattern);
        for (int unsigned k = 0; k < 64; k++) begin
            case (pattern)
                0: begin color_tab[k] = 24'hFF0000; grb_tab[k] = 24'h00FF00; end
                1: begin color_tab[k] = 24'h000001; grb_tab[k] = 24'h000001; end
                default: begin
                    case (k % 4)
                        0: begin color_tab[k] = 24'h123456; grb_tab[k] = 24'h341256; end
                        1: begin color_tab[k] = 24'hA5C30F; grb_tab[k] = 24'hC3A50F; end
                        2: begin color_tab[k] = 24'h00FF00; grb_tab[k] = 24'hFF0000; end
                        default: begin color_tab[k] = 24'h0000FF; grb_tab[k] = 24'h0000FF; end
                    endcase
                end
            endcase
        end
    endtask

    task automatic push_frame(input int unsigned l0);
        bit_exp_t    e;
        logic [23:0] g;
        for (int unsigned k = 0; k < LEDS; k++) begin
            g = grb_tab[k];
            for (int unsigned b = 0; b < 24; b++) begin
                e.rise  = l0 + k * (24 * TB + 1) + 1 + b * TB;
                e.width = g[23 - b] ? T1 : T0;
                e.addr  = 6'(k);
                bit_q.push_back(e);
            end
        end
        fd_q.push_back(l0 + FRAME);
    endtask

    task automatic start_pulse(output int unsigned l0);
        @(negedge clk);
        start = 1'b1;
        l0    = cyc + 1;
        push_frame(l0);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_fd(input int unsigned left, input int unsigned budget, input string name);
        int unsigned n = 0;
        while (fd_q.size() > left && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, fd_q.size(), left);
    endtask

    initial begin : monitor
        bit_exp_t e;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                in_high = 1'b0;
            end else begin
                if (dout === 1'b1) begin
                    if (!in_high) begin
                        in_high   = 1'b1;
                        rise_cyc  = cyc;
                        rise_addr = addr;
                        high_len  = 0;
                    end
                    high_len++;
                end else if (in_high) begin
                    in_high = 1'b0;
                    if (bit_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_bit actual=pulse_at_%0d required=none", rise_cyc);
                    end else begin
                        e = bit_q.pop_front();
                        chk("bit_rise_cycle", rise_cyc, e.rise);
                        chk("bit_high_width", high_len, e.width);
                        chk("bit_addr", rise_addr, e.addr);
                    end
                end
                if (frame_done === 1'b1) begin
                    if (fd_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame_done actual=pulse_at_%0d required=none", cyc);
                    end else begin
                        chk("frame_done_cycle", cyc, fd_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : main
        int unsigned l0;
        int unsigned n;
        int unsigned fd_cnt;
        int unsigned busy_cnt;

        rst_n = 1'b0;
        start = 1'b0;
        fill(0);
        repeat (3) @(negedge clk);
        #1;
        chk("reset_addr", addr, 0);
        chk("reset_busy", busy, 0);
        chk("reset_dout", dout, 0);
        chk("reset_frame_done", frame_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("idle_busy", busy, 0);

`ifdef WS2812_AUTO_REFRESH_EN
        fill(2);
        start_pulse(l0);
        push_frame(l0 + FRAME);
        n        = 0;
        busy_cnt = 0;
        while (fd_q.size() != 0 && n < 2 * FRAME + 200) begin
            @(negedge clk);
            #1;
            if (busy !== 1'b1) busy_cnt++;
            n++;
        end
        mon_en = 1'b0;
        chk("auto_frames_drained", fd_q.size(), 0);
        chk("auto_busy_low_cycles", busy_cnt, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("auto_reset_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
`else
        // FF0000 everywhere: per LED 8 short, 8 long, 8 short pulses
        fill(0);
        start_pulse(l0);
        #1;
        chk("frame_busy", busy, 1);
        wait_fd(0, FRAME + 200, "red_frame_done_seen");
        @(negedge clk);
        #1;
        chk("red_busy_after", busy, 0);

        // 000001: only the last bit of each LED is long
        fill(1);
        start_pulse(l0);
        wait_fd(0, FRAME + 200, "blue_frame_done_seen");
        @(negedge clk);
        #1;
        chk("blue_busy_after", busy, 0);

        // start held high: second frame loads the cycle after frame_done
        fill(2);
        @(negedge clk);
        start = 1'b1;
        l0    = cyc + 1;
        push_frame(l0);
        push_frame(l0 + FRAME + 1);
        wait_fd(1, FRAME + 200, "held_first_done_seen");
        repeat (5) @(negedge clk);
        #1;
        chk("held_restart_busy", busy, 1);
        start = 1'b0;
        wait_fd(0, FRAME + 200, "held_second_done_seen");
        repeat (20) @(negedge clk);
        #1;
        chk("held_no_third_frame", busy, 0);

        // reset asserted while LED 10 is high mid-bit
        fill(1);
        mon_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (addr != 6'd10 && n < FRAME) begin
            @(negedge clk);
            n++;
        end
        chk("reached_led10", addr, 10);
        repeat (TB * 5 + 1) @(negedge clk);
        chk("pre_reset_dout", dout, 1);
        rst_n = 1'b0;
        #1;
        chk("midreset_dout", dout, 0);
        chk("midreset_addr", addr, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_frame_done", frame_done, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        fd_cnt   = 0;
        busy_cnt = 0;
        for (int unsigned i = 0; i < FRAME + 50; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) fd_cnt++;
            if (busy !== 1'b0) busy_cnt++;
        end
        chk("postreset_frame_done_count", fd_cnt, 0);
        chk("postreset_busy_cycles", busy_cnt, 0);

        mon_en = 1'b1;
        fill(0);
        start_pulse(l0);
        wait_fd(0, FRAME + 200, "recovery_done_seen");
`endif

        chk("bit_queue_empty", bit_q.size(), 0);
        chk("frame_queue_empty", fd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
